phase_freq_detector: RTL and testbench

- Digital tri-state phase-frequency detector that drives the up/down inputs of the PLL loop filter, in the same clk domain.
- Synchronizes the asynchronous reference (ref_in) and divided feedback (fb_in) clocks, and detects their rising edges.
- Asserts up while the reference leads and down while the feedback leads.
- Reports a signed per-interval phase error, cycle slips and a lock indication for PLL status logic.

---
 rtl/pfd_pkg.sv | 14 +
 rtl/phase_freq_detector_if.sv | 24 ++
 rtl/phase_freq_detector_sync_edge_detect.sv | 48 ++++
 rtl/phase_freq_detector.sv | 149 ++++++++++++++
 tb/tb_phase_freq_detector.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pfd_pkg.sv
// Shared types and constants for the phase-frequency detector.
package pfd_pkg;

    typedef enum logic [1:0] {
        PFD_IDLE = 2'd0,
        PFD_UP   = 2'd1,
        PFD_DOWN = 2'd2
    } pfd_state_t;

    localparam int PFD_SYNC_STAGES  = 2;
    // clk edges from the first edge sampling an input high to up/down rising
    localparam int PFD_EDGE_LATENCY = 3;

endpackage

// File: rtl/phase_freq_detector_if.sv
// Detector bus: enable and the two async clocks in, loop-filter drive and status out.
interface phase_freq_detector_if #(
    parameter int WIDTH_W = 8
);
    logic                     enable;
    logic                     ref_in;
    logic                     fb_in;
    logic                     up;
    logic                     down;
    logic signed [WIDTH_W:0]  phase_err;
    logic                     phase_err_valid;
    logic                     cycle_slip;
    logic                     lock;

    modport master (
        output enable, ref_in, fb_in,
        input  up, down, phase_err, phase_err_valid, cycle_slip, lock
    );

    modport slave (
        input  enable, ref_in, fb_in,
        output up, down, phase_err, phase_err_valid, cycle_slip, lock
    );
endinterface

// File: rtl/phase_freq_detector_sync_edge_detect.sv
// Synchronizer chain plus rising-edge pulse; both detector inputs use one copy each so
// their relative timing is preserved.
module sync_edge_detect
    import pfd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);
    localparam int LAST = PFD_SYNC_STAGES - 1;

    logic [LAST:0] sync_q, sync_d;
    logic [LAST:0] fill_q, fill_d;
    logic          dly_q, dly_d;
    logic          armed_q, armed_d;

    // fill_q tracks when the chain holds real samples, so the reset-value zeros
    // cannot arm the detector for an input that was high through reset
    always_comb begin
        sync_d    = sync_q;
        fill_d    = fill_q;
        sync_d[0] = async_in;
        fill_d[0] = 1'b1;
        for (int i = 1; i <= LAST; i++) begin
            sync_d[i] = sync_q[i-1];
            fill_d[i] = fill_q[i-1];
        end
        dly_d   = sync_q[LAST];
        armed_d = armed_q | (fill_q[LAST] & ~sync_q[LAST]);
    end

    assign edge_pulse = sync_q[LAST] & ~dly_q & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            dly_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            dly_q   <= dly_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: rtl/phase_freq_detector.sv
// Tri-state phase-frequency detector with signed per-interval phase error,
// cycle-slip pulse and lock qualification.
module phase_freq_detector
    import pfd_pkg::*;
#(
    parameter int WIDTH_W  = 8,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    phase_freq_detector_if.slave bus
);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    logic                    ref_edge, fb_edge;
    pfd_state_t              state_q, state_d;
    logic [WIDTH_W-1:0]      width_q, width_d, width_inc, close_mag;
    logic signed [WIDTH_W:0] err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    slip_q, slip_d;
    logic                    lock_q, lock_d;
    logic [GOOD_W-1:0]       good_q, good_d;

    sync_edge_detect u_ref_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (bus.ref_in),
        .edge_pulse (ref_edge)
    );

    sync_edge_detect u_fb_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (bus.fb_in),
        .edge_pulse (fb_edge)
    );

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        slip_d    = 1'b0;
        good_d    = good_q;
        lock_d    = lock_q;
        close_mag = '0;
        width_inc = (&width_q) ? width_q : width_q + 1'b1;

        if (!bus.enable) begin
            // abort silently: no valid pulse, phase_err keeps its last value
            state_d = PFD_IDLE;
            width_d = '0;
            good_d  = '0;
            lock_d  = 1'b0;
        end else begin
            unique case (state_q)
                PFD_IDLE: begin
                    if (ref_edge && fb_edge) begin
                        valid_d = 1'b1;
                        err_d   = '0;
                    end else if (ref_edge) begin
                        state_d = PFD_UP;
                        width_d = WIDTH_W'(1);
                    end else if (fb_edge) begin
                        state_d = PFD_DOWN;
                        width_d = WIDTH_W'(1);
                    end
                end
                PFD_UP: begin
                    if (fb_edge) begin
                        valid_d   = 1'b1;
                        close_mag = width_q;
                        err_d     = $signed({1'b0, width_q});
                        if (ref_edge) begin
                            width_d = WIDTH_W'(1);
                        end else begin
                            state_d = PFD_IDLE;
                            width_d = '0;
                        end
                    end else begin
                        width_d = width_inc;
                        slip_d  = ref_edge;
                    end
                end
                PFD_DOWN: begin
                    if (ref_edge) begin
                        valid_d   = 1'b1;
                        close_mag = width_q;
                        err_d     = -$signed({1'b0, width_q});
                        if (fb_edge) begin
                            width_d = WIDTH_W'(1);
                        end else begin
                            state_d = PFD_IDLE;
                            width_d = '0;
                        end
                    end else begin
                        width_d = width_inc;
                        slip_d  = fb_edge;
                    end
                end
                default: begin
                    state_d = PFD_IDLE;
                    width_d = '0;
                end
            endcase

            if (slip_d) begin
                good_d = '0;
                lock_d = 1'b0;
            end else if (valid_d) begin
                if (int'(close_mag) <= LOCK_TOL) begin
                    if (int'(good_q) < LOCK_CNT) good_d = good_q + 1'b1;
                    if (int'(good_d) == LOCK_CNT) lock_d = 1'b1;
                end else begin
                    good_d = '0;
                    lock_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PFD_IDLE;
            width_q <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            slip_q  <= 1'b0;
            good_q  <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            slip_q  <= slip_d;
            good_q  <= good_d;
            lock_q  <= lock_d;
        end
    end

    assign bus.up              = (state_q == PFD_UP);
    assign bus.down            = (state_q == PFD_DOWN);
    assign bus.phase_err       = err_q;
    assign bus.phase_err_valid = valid_q;
    assign bus.cycle_slip      = slip_q;
    assign bus.lock            = lock_q;
endmodule

// File: tb/tb_phase_freq_detector.sv
// Scenario and randomized bench for phase_freq_detector against an interval-timestamp model.
module tb_phase_freq_detector;
    import pfd_pkg::*;

    localparam int W    = 8;
    localparam int TOL  = 2;
    localparam int LCNT = 16;
    localparam int WMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    phase_freq_detector_if #(.WIDTH_W(W)) bus ();

    phase_freq_detector #(.WIDTH_W(W), .LOCK_TOL(TOL), .LOCK_CNT(LCNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // sampled input history since reset release, one entry per posedge
    bit rh[$], fh[$], eh[$];
    // model: open interval direction (+1 ref leads, -1 fb leads, 0 none) and its start edge
    int m_open, m_start, m_good, m_err;
    bit m_up, m_down, m_valid, m_slip, m_lock;
    // stimulus waveform, one entry per cycle
    bit wr[$], wf[$], we[$];

    function automatic logic [13:0] dut_vec();
        return {bus.up, bus.down, bus.phase_err_valid, bus.cycle_slip, bus.lock, bus.phase_err};
    endfunction

    function automatic logic [13:0] mdl_vec();
        return {m_up, m_down, m_valid, m_slip, m_lock, 9'(m_err)};
    endfunction

    task automatic model_clear();
        rh.delete(); fh.delete(); eh.delete();
        m_open = 0; m_start = 0; m_good = 0; m_err = 0;
        m_up = 0; m_down = 0; m_valid = 0; m_slip = 0; m_lock = 0;
    endtask

    // A rising input sample becomes an event PFD_EDGE_LATENCY-1 posedges later.
    task automatic model_update();
        int j = rh.size() - 1;
        int k = j - PFD_EDGE_LATENCY;
        bit re, fe;
        int w;
        re = (k >= 0) && rh[k+1] && !rh[k];
        fe = (k >= 0) && fh[k+1] && !fh[k];
        w  = (j - m_start > WMAX) ? WMAX : j - m_start;
        m_valid = 0;
        m_slip  = 0;
        if (!eh[j]) begin
            m_open = 0; m_good = 0; m_lock = 0;
        end else begin
            if (m_open == 0) begin
                if (re && fe) begin m_valid = 1; m_err = 0; end
                else if (re) begin m_open = 1;  m_start = j; end
                else if (fe) begin m_open = -1; m_start = j; end
            end else if (m_open == 1) begin
                if (fe) begin
                    m_valid = 1; m_err = w;
                    if (re) m_start = j; else m_open = 0;
                end else if (re) m_slip = 1;
            end else begin
                if (re) begin
                    m_valid = 1; m_err = -w;
                    if (fe) m_start = j; else m_open = 0;
                end else if (fe) m_slip = 1;
            end
            if (m_slip) begin
                m_good = 0; m_lock = 0;
            end else if (m_valid) begin
                if ((m_err < 0 ? -m_err : m_err) <= TOL) begin
                    if (m_good < LCNT) m_good++;
                    if (m_good >= LCNT) m_lock = 1;
                end else begin
                    m_good = 0; m_lock = 0;
                end
            end
        end
        m_up   = (m_open == 1);
        m_down = (m_open == -1);
    endtask

    task automatic step();
        @(posedge clk);
        rh.push_back(bus.ref_in);
        fh.push_back(bus.fb_in);
        eh.push_back(bus.enable);
        model_update();
        #1;
    endtask

    task automatic apply(input int i);
        bus.ref_in = wr[i];
        bus.fb_in  = wf[i];
        bus.enable = we[i];
    endtask

    task automatic do_reset(input bit r, input bit f);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.ref_in = r; bus.fb_in = f; bus.enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic wave_clear();
        wr.delete(); wf.delete(); we.delete();
    endtask

    task automatic add_raw(input bit r, input bit f, input bit e);
        wr.push_back(r); wf.push_back(f); we.push_back(e);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add_raw(0, 0, 1);
    endtask

    // ref rises at offset a, fb at offset b, each held high 3 cycles
    task automatic add_pair(input int a, input int b);
        int len = ((a > b) ? a : b) + 7;
        for (int i = 0; i < len; i++)
            add_raw((i >= a && i < a + 3), (i >= b && i < b + 3), 1);
    endtask

    task automatic test_reset();
        do_reset(1, 1);
        tests++;
        if (dut_vec() !== 14'd0) begin
            fails++; $display("FAIL reset_values: got %b expected 0", dut_vec());
        end
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (dut_vec() !== mdl_vec() || bus.up || bus.down || bus.phase_err_valid) begin
                fails++; $display("FAIL reset_held_high cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_lead();
        int up_n = 0, dn_n = 0, v_n = 0, err = 0;
        wave_clear(); add_idle(6); add_pair(0, 5);
        for (int i = 0; i < wr.size(); i++) begin
            apply(i); step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lead cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
            up_n += bus.up; dn_n += bus.down;
            if (bus.phase_err_valid) begin v_n++; err = bus.phase_err; end
        end
        tests++;
        if (up_n != 5 || dn_n != 0 || v_n != 1 || err != 5) begin
            fails++; $display("FAIL lead_summary: got up=%0d down=%0d valid=%0d err=%0d expected 5 0 1 5", up_n, dn_n, v_n, err);
        end
    endtask

    task automatic test_lag();
        int up_n = 0, dn_n = 0, v_n = 0, err = 0;
        wave_clear(); add_idle(4); add_pair(3, 0);
        for (int i = 0; i < wr.size(); i++) begin
            apply(i); step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lag cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
            up_n += bus.up; dn_n += bus.down;
            if (bus.phase_err_valid) begin v_n++; err = bus.phase_err; end
        end
        tests++;
        if (up_n != 0 || dn_n != 3 || v_n != 1 || err != -3) begin
            fails++; $display("FAIL lag_summary: got up=%0d down=%0d valid=%0d err=%0d expected 0 3 1 -3", up_n, dn_n, v_n, err);
        end
    endtask

    task automatic test_coincident();
        int ud_n = 0, v_n = 0, err = 99;
        wave_clear(); add_idle(4); add_pair(0, 0);
        for (int i = 0; i < wr.size(); i++) begin
            apply(i); step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL coincident cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
            ud_n += bus.up + bus.down;
            if (bus.phase_err_valid) begin v_n++; err = bus.phase_err; end
        end
        tests++;
        if (ud_n != 0 || v_n != 1 || err != 0) begin
            fails++; $display("FAIL coincident_summary: got updown=%0d valid=%0d err=%0d expected 0 1 0", ud_n, v_n, err);
        end
    endtask

    task automatic test_lock();
        int k = 0;
        do_reset(0, 0);
        wave_clear(); add_idle(6);
        for (int p = 0; p < LCNT; p++) add_pair(0, 1);
        add_pair(0, 4);
        for (int i = 0; i < wr.size(); i++) begin
            apply(i); step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lock cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
            if (bus.phase_err_valid) begin
                k++;
                tests++;
                if (bus.lock !== (k == LCNT)) begin
                    fails++; $display("FAIL lock_at_interval %0d: got lock=%b expected %b", k, bus.lock, (k == LCNT));
                end
            end
        end
        tests++;
        if (k != LCNT + 1) begin
            fails++; $display("FAIL lock_interval_count: got %0d expected %0d", k, LCNT + 1);
        end
    endtask

    task automatic test_enable_abort();
        int v_n = 0;
        logic signed [W:0] held;
        held = bus.phase_err;
        wave_clear(); add_idle(6);
        for (int i = 0; i < 15; i++) add_raw(i < 3, 0, !(i >= 5 && i < 8));
        add_pair(0, 0);
        for (int i = 0; i < wr.size(); i++) begin
            apply(i); step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL enable cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
            if (i < 21) v_n += bus.phase_err_valid;
            if (i == 10 || i == 11) begin
                tests++;
                if (bus.up !== (i == 10)) begin
                    fails++; $display("FAIL enable_up_fall cyc %0d: got up=%b expected %b", i, bus.up, (i == 10));
                end
            end
            if (i == 20) begin
                tests++;
                if (bus.phase_err !== held) begin
                    fails++; $display("FAIL enable_err_hold: got %0d expected %0d", bus.phase_err, held);
                end
            end
        end
        tests++;
        if (v_n != 0) begin
            fails++; $display("FAIL enable_no_valid: got %0d pulses expected 0", v_n);
        end
    endtask

    task automatic test_slip();
        int up_n = 0, v_n = 0, s_n = 0, err = 0, base;
        bit prev_lock = 0;
        wave_clear(); add_idle(4);
        for (int p = 0; p < LCNT; p++) add_pair(0, 1);
        base = wr.size();
        for (int i = 0; i < 20; i++)
            add_raw((i < 3) || (i >= 8 && i < 11), (i >= 12 && i < 15), 1);
        add_idle(4);
        for (int i = 0; i < wr.size(); i++) begin
            apply(i); step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL slip cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
            if (i >= base) begin
                up_n += bus.up;
                if (bus.phase_err_valid) begin v_n++; err = bus.phase_err; end
            end
            if (bus.cycle_slip) begin
                s_n++;
                tests++;
                if (prev_lock !== 1'b1 || bus.lock !== 1'b0) begin
                    fails++; $display("FAIL slip_lock_drop: got before=%b at=%b expected 1 0", prev_lock, bus.lock);
                end
            end
            prev_lock = bus.lock;
        end
        tests++;
        if (s_n != 1 || up_n != 12 || v_n != 1 || err != 12) begin
            fails++; $display("FAIL slip_summary: got slips=%0d up=%0d valid=%0d err=%0d expected 1 12 1 12", s_n, up_n, v_n, err);
        end
    endtask

    task automatic test_saturation();
        int up_n = 0, err = 0;
        wave_clear(); add_idle(4);
        for (int i = 0; i < 310; i++) add_raw(i < 3, (i >= 300 && i < 303), 1);
        for (int i = 0; i < 12; i++) add_raw(i < 3, 0, 1);
        for (int i = 0; i < wr.size(); i++) begin
            apply(i); step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL saturation cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
            if (i < 314) up_n += bus.up;
            if (bus.phase_err_valid) err = bus.phase_err;
        end
        tests++;
        if (up_n != 300 || err != WMAX) begin
            fails++; $display("FAIL saturation_summary: got up=%0d err=%0d expected 300 %0d", up_n, err, WMAX);
        end
        // asynchronous reset in the middle of an open UP interval
        rst_n = 1'b0;
        #2;
        tests++;
        if (dut_vec() !== 14'd0) begin
            fails++; $display("FAIL async_reset: got %b expected 0", dut_vec());
        end
        do_reset(0, 0);
    endtask

    task automatic test_random();
        int v_n = 0, rr, fr;
        bit rl = 0, fl = 0;
        wave_clear(); add_idle(6);
        rr = $urandom_range(2, 7);
        fr = $urandom_range(2, 7);
        for (int i = 0; i < 800; i++) begin
            add_raw(rl, fl, $urandom_range(0, 99) >= 3);
            if (--rr == 0) begin rl = !rl; rr = $urandom_range(2, 7); end
            if (--fr == 0) begin fl = !fl; fr = $urandom_range(2, 7); end
        end
        for (int i = 0; i < wr.size(); i++) begin
            apply(i); step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL random cyc %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
            v_n += bus.phase_err_valid;
        end
        tests++;
        if (v_n == 0) begin
            fails++; $display("FAIL random_activity: got %0d valid pulses expected >0", v_n);
        end
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
        model_clear();
        test_reset();
        test_lead();
        test_lag();
        test_coincident();
        test_lock();
        test_enable_abort();
        test_slip();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
